// File: rtl/qam16_bit_source_packer.sv
// Paced serial bit source plus 4-bit MSB-first serial-to-parallel packer for the 16-QAM mapper.
// Define QAM_PRBS_EN to use a PRBS-7 source; otherwise a 4-bit counter pattern is serialized.
module qam16_bit_source_packer #(
    parameter int         BIT_PERIOD = 8,
    parameter logic [6:0] SEED       = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       serial_in,
    output logic       data_flag,
    output logic [3:0] parallel_data,
    output logic       sym_valid
);

    localparam logic [7:0] CNT_LAST = 8'(BIT_PERIOD - 1);

    logic [7:0] cnt;
    logic [1:0] idx;
    logic [2:0] sr;
    logic       src_bit;

`ifdef QAM_PRBS_EN
    // An all-zero LFSR would lock up, so a zero seed falls back to all ones.
    localparam logic [6:0] SEED_EFF = (SEED == 7'd0) ? 7'h7F : SEED;
    logic [6:0] lfsr;
    assign src_bit = lfsr[6];
`else
    logic [3:0] pat;
    logic [1:0] pos;
    assign src_bit = pat[2'd3 - pos];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            serial_in <= 1'b0;
            data_flag <= 1'b0;
`ifdef QAM_PRBS_EN
            lfsr      <= SEED_EFF;
`else
            pat       <= '0;
            pos       <= '0;
`endif
        end else if (start) begin
            if (cnt == 8'd0) begin
                serial_in <= src_bit;
                data_flag <= 1'b1;
`ifdef QAM_PRBS_EN
                lfsr      <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`else
                pos       <= pos + 2'd1;
                if (pos == 2'd3)
                    pat <= pat + 4'd1;
`endif
            end else begin
                data_flag <= 1'b0;
            end
            cnt <= (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
        end else begin
            data_flag <= 1'b0;
        end
    end

    // Packer consumes the registered bit one clock after its strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            sr            <= '0;
            parallel_data <= '0;
            sym_valid     <= 1'b0;
        end else if (start && data_flag) begin
            sr  <= {sr[1:0], serial_in};
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                parallel_data <= {sr, serial_in};
                sym_valid     <= 1'b1;
            end else begin
                sym_valid <= 1'b0;
            end
        end else begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qam16_bit_source_packer.sv
// Directed bench: BIT_PERIOD=8 instance (default seed) and BIT_PERIOD=1 instance (SEED=0).
module tb_qam16_bit_source_packer;

    typedef struct {
        int         edge_no;
        logic [3:0] sym;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, start_a, rst_b, start_b;
    logic si_a, df_a, sv_a, si_b, df_b, sv_b;
    logic [3:0] pd_a, pd_b;

    int tests = 0;
    int fails = 0;
    int n = 0;
    bit sel_b = 1'b0;
    vec_t vecs[17];

    always #5 clk = ~clk;

    qam16_bit_source_packer #(.BIT_PERIOD(8)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .serial_in(si_a),
        .data_flag(df_a), .parallel_data(pd_a), .sym_valid(sv_a)
    );

    qam16_bit_source_packer #(.BIT_PERIOD(1), .SEED(7'h00)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .serial_in(si_b),
        .data_flag(df_b), .parallel_data(pd_b), .sym_valid(sv_b)
    );

    // k-th source bit after reset, straight from the source definition.
    function automatic logic src_bit(input int k);
`ifdef QAM_PRBS_EN
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < k; i++) s = {s[5:0], s[6] ^ s[5]};
        return s[6];
`else
        logic [3:0] p;
        p = 4'((k / 4) % 16);
        return p[3 - (k % 4)];
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic wait_sym(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((sel_b ? sv_b : sv_a) === 1'b1) begin
                at = n;
                break;
            end
        end
    endtask

    task automatic do_reset(input bit b);
        sel_b = b;
        if (b) begin rst_b = 1'b1; start_b = 1'b0; end
        else   begin rst_a = 1'b1; start_a = 1'b0; end
        step();
        if (b) begin rst_b = 1'b0; start_b = 1'b1; end
        else   begin rst_a = 1'b0; start_a = 1'b1; end
        n = 0;
    endtask

    initial begin
        int at, cnt_sym;
        bit bad;
        rst_a = 1'b1; start_a = 1'b0; rst_b = 1'b1; start_b = 1'b0;

        for (int i = 0; i < 17; i++) begin
            vecs[i].edge_no = 26 + 32 * i;
            for (int j = 0; j < 4; j++) vecs[i].sym[3 - j] = src_bit(4 * i + j);
        end

        // reset state
        step();
        check("rst_serial_in", int'(si_a), 0);
        check("rst_data_flag", int'(df_a), 0);
        check("rst_parallel_data", int'(pd_a), 0);
        check("rst_sym_valid", int'(sv_a), 0);
        check("rst_b_outputs", int'({si_b, df_b, pd_b, sv_b}), 0);

        // first eight bits and strobe timing
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            while (n < 1 + 8 * k) step();
            check($sformatf("bit%0d_serial_in", k), int'(si_a), int'(src_bit(k)));
            check($sformatf("bit%0d_flag_hi", k), int'(df_a), 1);
            step();
            check($sformatf("bit%0d_flag_lo", k), int'(df_a), 0);
        end

        // symbol stream, table-driven
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            wait_sym(40, at);
            check($sformatf("sym%0d_edge", i), at, vecs[i].edge_no);
            check($sformatf("sym%0d_data", i), int'(pd_a), int'(vecs[i].sym));
            step();
            check($sformatf("sym%0d_pulse_width", i), int'(sv_a), 0);
        end

        // start gap between 2nd and 3rd bit
        do_reset(1'b0);
        while (n < 12) step();
        start_a = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            step();
            if (df_a !== 1'b0 || sv_a !== 1'b0) bad = 1'b1;
        end
        check("gap_quiet", int'(bad), 0);
        start_a = 1'b1;
        wait_sym(80, at);
        check("gap_sym0_edge", at, 46);
        check("gap_sym0_data", int'(pd_a), int'(vecs[0].sym));
        wait_sym(40, at);
        check("gap_sym1_edge", at, 78);
        check("gap_sym1_data", int'(pd_a), int'(vecs[1].sym));

        // one-cycle reset mid-symbol
        do_reset(1'b0);
        while (n < 40) step();
        rst_a = 1'b1;
        step();
        check("midrst_outputs", int'({si_a, df_a, pd_a, sv_a}), 0);
        rst_a = 1'b0;
        n = 0;
        wait_sym(40, at);
        check("midrst_sym0_edge", at, 26);
        check("midrst_sym0_data", int'(pd_a), int'(vecs[0].sym));
        wait_sym(40, at);
        check("midrst_sym1_edge", at, 58);
        check("midrst_sym1_data", int'(pd_a), int'(vecs[1].sym));
        start_a = 1'b0;

        // BIT_PERIOD=1, zero seed
        do_reset(1'b1);
        bad = 1'b0;
        cnt_sym = 0;
        for (int e = 1; e <= 37; e++) begin
            step();
            if (df_b !== 1'b1) bad = 1'b1;
            if (sv_b === 1'b1) begin
                if (cnt_sym < 9) begin
                    check($sformatf("p1_sym%0d_edge", cnt_sym), n, 5 + 4 * cnt_sym);
                    check($sformatf("p1_sym%0d_data", cnt_sym), int'(pd_b), int'(vecs[cnt_sym].sym));
                end
                cnt_sym++;
            end
        end
        check("p1_flag_constant", int'(bad), 0);
        check("p1_sym_count", cnt_sym, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
